// File: rtl/bitserial_alu_if.sv
// Operand/result bundle for bitserial_alu: one request channel in, one result channel out.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid and
// ready are both high; the source holds its payload stable while valid is high and ready low.
interface bitserial_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       command;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, command, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, command, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero
  );
endinterface

// File: rtl/bitserial_alu.sv
// Bit-serial ALU sequencer: walks one 1-bit ALU slice over WIDTH bits, LSB first.
// Define ALU_SLT_EN to make command 3 a signed set-less-than; otherwise command 3 is ADD.
module bitserial_alu #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bitserial_alu_if.slave        bus,
  output logic [1:0]            state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } cmd_e;

  state_e           state_q, state_d;
  cmd_e             cmd_q, cmd_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_sh_q, result_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             nz_q, nz_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic invtb;
  logic s_bb, s_sum, s_cout, s_res, s_zout;

  // Subtract-like commands invert B and start with carry-in 1 (two's complement).
  function automatic logic sub_like(input cmd_e c);
`ifdef ALU_SLT_EN
    return (c == CMD_SUB) || (c == CMD_SLT);
`else
    return (c == CMD_SUB);
`endif
  endfunction

  function automatic logic is_arith(input cmd_e c);
    return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_SLT);
  endfunction

  // One-bit ALU slice.
  always_comb begin
    invtb  = sub_like(cmd_q);
    s_bb   = b_sh_q[0] ^ invtb;
    s_sum  = a_sh_q[0] ^ s_bb ^ carry_q;
    s_cout = (a_sh_q[0] & s_bb) | (carry_q & (a_sh_q[0] ^ s_bb));
    s_res  = s_sum;
    case (cmd_q)
      CMD_XOR:  s_res = a_sh_q[0] ^ b_sh_q[0];
      CMD_AND:  s_res = a_sh_q[0] & b_sh_q[0];
      CMD_NAND: s_res = ~(a_sh_q[0] & b_sh_q[0]);
      CMD_NOR:  s_res = ~(a_sh_q[0] | b_sh_q[0]);
      CMD_OR:   s_res = a_sh_q[0] | b_sh_q[0];
      default:  s_res = s_sum;
    endcase
    s_zout = nz_q | s_res;
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    result_sh_d = result_sh_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    nz_d        = nz_q;
    result_d    = result_q;
    carryout_d  = carryout_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          cmd_d   = cmd_e'(bus.command);
          cnt_d   = '0;
          nz_d    = 1'b0;
          carry_d = sub_like(cmd_e'(bus.command));
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d      = a_sh_q >> 1;
        b_sh_d      = b_sh_q >> 1;
        result_sh_d = {s_res, result_sh_q[WIDTH-1:1]};
        carry_d     = s_cout;
        nz_d        = s_zout;
        cnt_d       = cnt_q + CW'(1);
        // On the MSB bit carry_q is the carry into the MSB and s_sum its sum bit.
        if (cnt_q == LAST) begin
          state_d    = DONE;
          result_d   = {s_res, result_sh_q[WIDTH-1:1]};
          carryout_d = 1'b0;
          overflow_d = 1'b0;
          zero_d     = ~s_zout;
`ifdef ALU_SLT_EN
          if (cmd_q == CMD_SLT) begin
            result_d = {{(WIDTH-1){1'b0}}, s_sum ^ carry_q ^ s_cout};
            zero_d   = ~(s_sum ^ carry_q ^ s_cout);
          end else
`endif
          if (is_arith(cmd_q)) begin
            carryout_d = s_cout;
            overflow_d = carry_q ^ s_cout;
          end
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= CMD_ADD;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      result_sh_q <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      nz_q        <= 1'b0;
      result_q    <= '0;
      carryout_q  <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      result_sh_q <= result_sh_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      nz_q        <= nz_d;
      result_q    <= result_d;
      carryout_q  <= carryout_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carryout  = carryout_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
  assign state_o       = state_q;

endmodule
